solitaire_ctrl: RTL and testbench
=================================

SOLITAIRE_CTRL -- requirements
Module: solitaire_ctrl

Interface
REQ-001 SHALL have parameter BOARD_WIDTH, default 7, board edge length in squares.
REQ-002 SHALL have parameter PARK_XY, default 3'd7, coordinate driven on core_x/core_y when no move is issued.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports btn_left/btn_right/btn_up/btn_down, input, 1 each, single-cycle pulses, already debounced.
REQ-006 SHALL have ports btn_select, btn_cancel, btn_new, input, 1 each, single-cycle pulses.
REQ-007 SHALL have ports core_x, core_y, output, 3 each, square coordinates to the board core.
REQ-008 SHALL have port core_dir, output, 2, move direction: LEFT=00, RIGHT=01, UP=10 (y decreasing), DOWN=11.
REQ-009 SHALL have port core_rst_n, output, 1, registered active-low reset to the board core.
REQ-010 SHALL have ports core_piece_count (6) and core_game_over (1), inputs from the board core.
REQ-011 SHALL have ports cursor_x, cursor_y, output, 3 each; aiming, output, 1; high in AIM.
REQ-012 SHALL have ports move_ok, move_err, output, 1 each, single-cycle result pulses; move_cnt, output, 5, accepted moves; game_over, output, 1.

Function
REQ-013 SHALL implement states BROWSE, AIM, ISSUE, CHECK, OVER.
REQ-014 SHALL drive core_x = core_y = PARK_XY and core_dir = 00 in every state except ISSUE, so the core sees no move request.
REQ-015 SHALL act on at most one button per cycle, priority btn_new > left > right > up > down > select > cancel; lower-priority pulses that cycle are dropped.
REQ-016 In BROWSE, direction buttons SHALL move the cursor by 1 with wrap 0..BOARD_WIDTH-1 (6+1 -> 0, 0-1 -> 6); btn_select SHALL go to AIM.
REQ-017 In AIM, a direction button SHALL latch that direction and go to ISSUE; btn_cancel SHALL return to BROWSE with cursor unchanged; btn_select ignored.
REQ-018 ISSUE SHALL last exactly one cycle, driving core_x/core_y = cursor and core_dir = latched direction, and SHALL snapshot core_piece_count; next state CHECK.
REQ-019 In CHECK (one cycle): if core_piece_count == snapshot-1, SHALL pulse move_ok, increment move_cnt, and move cursor 2 squares in the latched direction (landing square); otherwise SHALL pulse move_err, cursor and move_cnt unchanged.
REQ-020 From CHECK SHALL go to OVER if core_game_over=1, else BROWSE; game_over output SHALL be high exactly while in OVER.
REQ-021 move_cnt SHALL saturate at 31.
REQ-022 In OVER, all buttons except btn_new SHALL be ignored.
REQ-023 btn_new SHALL be honoured in BROWSE, AIM and OVER (ignored in ISSUE/CHECK): drive core_rst_n=0 for exactly one cycle, cursor -> (3,3), move_cnt -> 0, state -> BROWSE.
REQ-024 Buttons arriving during ISSUE or CHECK SHALL be dropped, not queued.

Reset
REQ-025 While rst=1: state BROWSE, cursor (3,3), core_x/core_y = PARK_XY, core_dir 00, core_rst_n 0, move_ok/move_err 0, move_cnt 0, game_over 0, aiming 0.
REQ-026 core_rst_n SHALL rise at the first clk edge after rst deasserts.
REQ-027 rst asserted mid-ISSUE or mid-CHECK SHALL abort the move with no move_ok/move_err pulse.

Verification
REQ-028 Reset, btn_left x4 -> cursor_x 3,2,1,0,6; cursor_y stays 3; core_x/core_y stay 7.
REQ-029 Reset, btn_down x2, select, btn_up -> ISSUE drives (3,5,UP) one cycle; core count 32->31; move_ok pulse, move_cnt 1, cursor (3,3).
REQ-030 Reset, select, btn_left at empty (3,3) -> move_err pulse, move_cnt 0, cursor (3,3), core count stays 32.
REQ-031 select then btn_cancel -> aiming 1 then 0, state BROWSE, no ISSUE cycle, core_x stays 7.
REQ-032 Model core with core_game_over=1 after an accepted move -> game_over 1, direction/select ignored; btn_new -> core_rst_n low one cycle, move_cnt 0, cursor (3,3), game_over 0.
REQ-033 btn_left and btn_select in same cycle in BROWSE -> only cursor moves left, state stays BROWSE.

Source files
------------

// File: rtl/solitaire_ctrl.sv
// Peg-solitaire player controller: turns debounced button pulses into cursor
// movement and one-cycle move requests to the board core, then checks the result.
module solitaire_ctrl #(
  parameter int         BOARD_WIDTH = 7,
  parameter logic [2:0] PARK_XY     = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_cancel,
  input  logic       btn_new,
  output logic [2:0] core_x,
  output logic [2:0] core_y,
  output logic [1:0] core_dir,
  output logic       core_rst_n,
  input  logic [5:0] core_piece_count,
  input  logic       core_game_over,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       aiming,
  output logic       move_ok,
  output logic       move_err,
  output logic [4:0] move_cnt,
  output logic       game_over
);

  typedef enum logic [2:0] {S_BROWSE, S_AIM, S_ISSUE, S_CHECK, S_OVER} state_e;
  typedef enum logic [1:0] {DIR_LEFT = 2'b00, DIR_RIGHT = 2'b01,
                            DIR_UP = 2'b10, DIR_DOWN = 2'b11} dir_e;
  typedef enum logic [2:0] {B_NONE, B_NEW, B_LEFT, B_RIGHT, B_UP, B_DOWN,
                            B_SELECT, B_CANCEL} btn_e;

  localparam logic [2:0] HOME_XY = 3'd3;

  state_e     r_state;
  dir_e       r_dir;
  dir_e       r_core_dir;
  logic [2:0] r_core_x, r_core_y;
  logic [2:0] r_cursor_x, r_cursor_y;
  logic [5:0] r_snap;
  logic [4:0] r_move_cnt;
  logic       r_core_rst_n, r_aiming, r_move_ok, r_move_err, r_game_over;

  btn_e       w_btn;
  dir_e       w_btn_dir;
  logic       w_is_dir;
  logic       w_new_ok;
  logic [2:0] w_step_x, w_step_y, w_land_x, w_land_y;

  function automatic logic [2:0] wrap_add(input logic [2:0] p, input logic [2:0] n);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, n};
    if (s >= 4'(BOARD_WIDTH)) s = s - 4'(BOARD_WIDTH);
    return s[2:0];
  endfunction

  function automatic logic [2:0] wrap_sub(input logic [2:0] p, input logic [2:0] n);
    logic [3:0] s;
    if (p >= n) s = {1'b0, p} - {1'b0, n};
    else        s = {1'b0, p} + 4'(BOARD_WIDTH) - {1'b0, n};
    return s[2:0];
  endfunction

  // Only the highest-priority pulse of a cycle is seen; the rest are dropped.
  always_comb begin
    w_btn = B_NONE;
    if      (btn_new)    w_btn = B_NEW;
    else if (btn_left)   w_btn = B_LEFT;
    else if (btn_right)  w_btn = B_RIGHT;
    else if (btn_up)     w_btn = B_UP;
    else if (btn_down)   w_btn = B_DOWN;
    else if (btn_select) w_btn = B_SELECT;
    else if (btn_cancel) w_btn = B_CANCEL;
  end

  always_comb begin
    w_is_dir  = 1'b1;
    w_btn_dir = DIR_LEFT;
    case (w_btn)
      B_LEFT:  w_btn_dir = DIR_LEFT;
      B_RIGHT: w_btn_dir = DIR_RIGHT;
      B_UP:    w_btn_dir = DIR_UP;
      B_DOWN:  w_btn_dir = DIR_DOWN;
      default: w_is_dir  = 1'b0;
    endcase
  end

  assign w_new_ok = (w_btn == B_NEW) &&
                    (r_state == S_BROWSE || r_state == S_AIM || r_state == S_OVER);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_step_x = r_cursor_x;
    w_step_y = r_cursor_y;
    case (w_btn_dir)
      DIR_LEFT:  w_step_x = wrap_sub(r_cursor_x, 3'd1);
      DIR_RIGHT: w_step_x = wrap_add(r_cursor_x, 3'd1);
      DIR_UP:    w_step_y = wrap_sub(r_cursor_y, 3'd1);
      DIR_DOWN:  w_step_y = wrap_add(r_cursor_y, 3'd1);
      default:   ;
    endcase
  end

  // The jump lands two squares away in the latched direction.
  always_comb begin
    w_land_x = r_cursor_x;
    w_land_y = r_cursor_y;
    case (r_dir)
      DIR_LEFT:  w_land_x = wrap_sub(r_cursor_x, 3'd2);
      DIR_RIGHT: w_land_x = wrap_add(r_cursor_x, 3'd2);
      DIR_UP:    w_land_y = wrap_sub(r_cursor_y, 3'd2);
      DIR_DOWN:  w_land_y = wrap_add(r_cursor_y, 3'd2);
      default:   ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates take
  // effect together at the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BROWSE;
      r_dir        <= DIR_LEFT;
      r_core_dir   <= DIR_LEFT;
      r_core_x     <= PARK_XY;
      r_core_y     <= PARK_XY;
      r_cursor_x   <= HOME_XY;
      r_cursor_y   <= HOME_XY;
      r_snap       <= '0;
      r_move_cnt   <= '0;
      r_core_rst_n <= 1'b0;
      r_aiming     <= 1'b0;
      r_move_ok    <= 1'b0;
      r_move_err   <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_core_rst_n <= 1'b1;
      r_move_ok    <= 1'b0;
      r_move_err   <= 1'b0;
      if (w_new_ok) begin
        r_state      <= S_BROWSE;
        r_core_rst_n <= 1'b0;
        r_cursor_x   <= HOME_XY;
        r_cursor_y   <= HOME_XY;
        r_move_cnt   <= '0;
        r_aiming     <= 1'b0;
        r_game_over  <= 1'b0;
      end else begin
        case (r_state)
          S_BROWSE: begin
            if (w_is_dir) begin
              r_cursor_x <= w_step_x;
              r_cursor_y <= w_step_y;
            end else if (w_btn == B_SELECT) begin
              r_state  <= S_AIM;
              r_aiming <= 1'b1;
            end
          end
          S_AIM: begin
            if (w_is_dir) begin
              r_dir      <= w_btn_dir;
              r_core_dir <= w_btn_dir;
              r_core_x   <= r_cursor_x;
              r_core_y   <= r_cursor_y;
              r_aiming   <= 1'b0;
              r_state    <= S_ISSUE;
            end else if (w_btn == B_CANCEL) begin
              r_aiming <= 1'b0;
              r_state  <= S_BROWSE;
            end
          end
          S_ISSUE: begin
            // The core applies the move on this edge, so this is the pre-move count.
            r_snap     <= core_piece_count;
            r_core_x   <= PARK_XY;
            r_core_y   <= PARK_XY;
            r_core_dir <= DIR_LEFT;
            r_state    <= S_CHECK;
          end
          S_CHECK: begin
            if (core_piece_count == r_snap - 6'd1) begin
              r_move_ok  <= 1'b1;
              r_cursor_x <= w_land_x;
              r_cursor_y <= w_land_y;
              if (r_move_cnt != 5'd31) r_move_cnt <= r_move_cnt + 5'd1;
            end else begin
              r_move_err <= 1'b1;
            end
            if (core_game_over) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state <= S_BROWSE;
            end
          end
          S_OVER:  ;
          default: r_state <= S_BROWSE;
        endcase
      end
    end
  end

  assign core_x     = r_core_x;
  assign core_y     = r_core_y;
  assign core_dir   = r_core_dir;
  assign core_rst_n = r_core_rst_n;
  assign cursor_x   = r_cursor_x;
  assign cursor_y   = r_cursor_y;
  assign aiming     = r_aiming;
  assign move_ok    = r_move_ok;
  assign move_err   = r_move_err;
  assign move_cnt   = r_move_cnt;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_solitaire_ctrl.sv
// Bench for solitaire_ctrl: a behavioural English-board core model, a vector
// table for cursor/priority behaviour, and a result scoreboard for moves.
module tb_solitaire_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left, btn_right, btn_up, btn_down, btn_select, btn_cancel, btn_new;
  logic [2:0] core_x, core_y, cursor_x, cursor_y;
  logic [1:0] core_dir;
  logic       core_rst_n, core_game_over, aiming, move_ok, move_err, game_over;
  logic [5:0] core_piece_count;
  logic [4:0] move_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] NEW = 7'b1000000, L = 7'b0100000, R = 7'b0010000,
                         U = 7'b0001000, D = 7'b0000100, SEL = 7'b0000010,
                         CAN = 7'b0000001;

  solitaire_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_select(btn_select), .btn_cancel(btn_cancel), .btn_new(btn_new),
    .core_x(core_x), .core_y(core_y), .core_dir(core_dir), .core_rst_n(core_rst_n),
    .core_piece_count(core_piece_count), .core_game_over(core_game_over),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .aiming(aiming),
    .move_ok(move_ok), .move_err(move_err), .move_cnt(move_cnt), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ---------------- board core model ----------------
  bit         board [0:6][0:6];
  logic [5:0] count;
  bit         fake = 1'b0;
  bit         go_en = 1'b0;

  function automatic bit sq_valid(int x, int y);
    return x >= 0 && x < 7 && y >= 0 && y < 7 && !((x < 2 || x > 4) && (y < 2 || y > 4));
  endfunction
  function automatic int ddx(logic [1:0] d);
    return (d == 2'b00) ? -1 : (d == 2'b01) ? 1 : 0;
  endfunction
  function automatic int ddy(logic [1:0] d);
    return (d == 2'b10) ? -1 : (d == 2'b11) ? 1 : 0;
  endfunction
  function automatic bit legal(int x, int y, logic [1:0] d);
    int tx = x + 2 * ddx(d);
    int ty = y + 2 * ddy(d);
    if (!sq_valid(x, y) || !sq_valid(tx, ty)) return 1'b0;
    return board[x][y] && board[x + ddx(d)][y + ddy(d)] && !board[tx][ty];
  endfunction

  always @(posedge clk) begin
    if (!core_rst_n) begin
      for (int x = 0; x < 7; x++)
        for (int y = 0; y < 7; y++)
          board[x][y] <= sq_valid(x, y) && !(x == 3 && y == 3);
      count <= 6'd32;
    end else if (core_x != 3'd7) begin
      if (fake) count <= count - 6'd1;
      else if (legal(int'(core_x), int'(core_y), core_dir)) begin
        board[core_x][core_y] <= 1'b0;
        board[int'(core_x) + ddx(core_dir)][int'(core_y) + ddy(core_dir)] <= 1'b0;
        board[int'(core_x) + 2 * ddx(core_dir)][int'(core_y) + 2 * ddy(core_dir)] <= 1'b1;
        count <= count - 6'd1;
      end
    end
  end

  assign core_piece_count = count;
  assign core_game_over   = go_en && (count != 6'd32);

  // ---------------- helpers ----------------
  typedef struct packed {
    logic       ok;
    logic [4:0] cnt;
    logic [2:0] x;
    logic [2:0] y;
  } res_t;
  res_t sb[$];

  typedef struct packed {
    logic [6:0] btn;
    logic [2:0] ex;
    logic [2:0] ey;
    logic       ea;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] b);
    {btn_new, btn_left, btn_right, btn_up, btn_down, btn_select, btn_cancel} = b;
  endtask

  task automatic press(input logic [6:0] b);
    drive(b);
    @(negedge clk);
    drive(7'd0);
  endtask

  function automatic logic [2:0] wrap7(int v);
    return 3'(((v % 7) + 7) % 7);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(7'd0);
    #1;
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_core_x", core_x, 7);
    check("rst_core_y", core_y, 7);
    check("rst_core_dir", core_dir, 0);
    check("rst_cursor", {cursor_x, cursor_y}, {3'd3, 3'd3});
    check("rst_flags", {aiming, move_ok, move_err, game_over}, 0);
    check("rst_move_cnt", move_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("core_rst_n_before_edge", core_rst_n, 0);
    @(negedge clk);
    check("core_rst_n_after_edge", core_rst_n, 1);
  endtask

  task automatic expect_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("no_result_pulse", {move_ok, move_err}, 0);
    end
  endtask

  task automatic wait_result();
    int   n = 0;
    res_t e;
    while (!(move_ok || move_err) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) check("result_timeout", 0, 1);
    else if (sb.size() == 0) check("scoreboard_empty", 0, 1);
    else begin
      e = sb.pop_front();
      check("move_ok", move_ok, e.ok);
      check("move_err", move_err, !e.ok);
      check("move_cnt", move_cnt, e.cnt);
      check("cursor_after_move", {cursor_x, cursor_y}, {e.x, e.y});
      @(negedge clk);
      check("pulse_one_cycle", {move_ok, move_err}, 0);
      check("cursor_stable", {cursor_x, cursor_y}, {e.x, e.y});
    end
  endtask

  // Starts in AIM; noise is pulsed throughout ISSUE and CHECK and must be dropped.
  task automatic move_seq(input logic [6:0] dbtn, input logic [1:0] dir, input logic exp_ok,
                          input logic [2:0] cx, input logic [2:0] cy,
                          input logic [4:0] exp_cnt, input logic [6:0] noise);
    res_t e;
    e.ok  = exp_ok;
    e.cnt = exp_cnt;
    e.x   = exp_ok ? wrap7(int'(cx) + 2 * ddx(dir)) : cx;
    e.y   = exp_ok ? wrap7(int'(cy) + 2 * ddy(dir)) : cy;
    sb.push_back(e);
    press(dbtn);
    check("issue_core_xy", {core_x, core_y}, {cx, cy});
    check("issue_core_dir", core_dir, dir);
    drive(noise);
    @(negedge clk);
    check("check_core_parked", {core_x, core_y, core_dir}, {3'd7, 3'd7, 2'd0});
    @(negedge clk);
    drive(7'd0);
    wait_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] cx;
    logic [4:0] ec;
    vecs[0]  = '{L,       3'd2, 3'd3, 1'b0};
    vecs[1]  = '{L,       3'd1, 3'd3, 1'b0};
    vecs[2]  = '{L,       3'd0, 3'd3, 1'b0};
    vecs[3]  = '{L,       3'd6, 3'd3, 1'b0};
    vecs[4]  = '{R,       3'd0, 3'd3, 1'b0};
    vecs[5]  = '{U,       3'd0, 3'd2, 1'b0};
    vecs[6]  = '{D,       3'd0, 3'd3, 1'b0};
    vecs[7]  = '{L | SEL, 3'd6, 3'd3, 1'b0};
    vecs[8]  = '{U | D,   3'd6, 3'd2, 1'b0};
    vecs[9]  = '{R | U,   3'd0, 3'd2, 1'b0};
    vecs[10] = '{SEL,     3'd0, 3'd2, 1'b1};
    vecs[11] = '{SEL,     3'd0, 3'd2, 1'b1};
    vecs[12] = '{CAN,     3'd0, 3'd2, 1'b0};
    vecs[13] = '{CAN,     3'd0, 3'd2, 1'b0};

    rst = 1'b1;
    drive(7'd0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      press(vecs[i].btn);
      check($sformatf("vec%0d_cursor", i), {cursor_x, cursor_y}, {vecs[i].ex, vecs[i].ey});
      check($sformatf("vec%0d_aiming", i), aiming, vecs[i].ea);
      check($sformatf("vec%0d_core_parked", i), {core_x, core_y}, {3'd7, 3'd7});
    end

    // Accepted jump up from (3,5) into the empty centre.
    do_reset();
    press(D);
    press(D);
    check("cursor_3_5", {cursor_x, cursor_y}, {3'd3, 3'd5});
    press(SEL);
    move_seq(U, 2'b10, 1'b1, 3'd3, 3'd5, 5'd1, L);
    check("core_count_31", count, 31);
    check("not_over", game_over, 0);

    // Rejected move: source square is empty.
    do_reset();
    press(SEL);
    move_seq(L, 2'b00, 1'b0, 3'd3, 3'd3, 5'd0, 7'd0);
    check("core_count_32", count, 32);

    // btn_new while aiming.
    press(SEL);
    press(NEW);
    check("new_aim_rst_n", core_rst_n, 0);
    check("new_aim_aiming", aiming, 0);
    @(negedge clk);
    check("new_aim_rst_n_rise", core_rst_n, 1);

    // Game over after an accepted move.
    do_reset();
    go_en = 1'b1;
    press(D);
    press(D);
    press(SEL);
    move_seq(U, 2'b10, 1'b1, 3'd3, 3'd5, 5'd1, 7'd0);
    check("over_game_over", game_over, 1);
    press(L);
    check("over_left_ignored", {cursor_x, cursor_y}, {3'd3, 3'd3});
    press(SEL);
    check("over_select_ignored", {aiming, game_over}, {1'b0, 1'b1});
    press(NEW | L);
    check("over_new_rst_n", core_rst_n, 0);
    check("over_new_state", {move_cnt, cursor_x, cursor_y, game_over},
          {5'd0, 3'd3, 3'd3, 1'b0});
    @(negedge clk);
    check("over_new_rst_n_rise", core_rst_n, 1);
    @(negedge clk);
    check("over_new_core_count", count, 32);
    go_en = 1'b0;

    // Reset during ISSUE, then during CHECK: no result pulse may appear.
    do_reset();
    press(D);
    press(D);
    press(SEL);
    press(U);
    check("abort_issue_core_x", core_x, 3);
    do_reset();
    expect_quiet(3);
    check("abort_issue_cnt", move_cnt, 0);
    press(D);
    press(D);
    press(SEL);
    press(U);
    @(negedge clk);
    do_reset();
    expect_quiet(3);
    check("abort_check_cnt", move_cnt, 0);

    // Saturation: core that accepts every request; btn_new noise must be ignored.
    do_reset();
    fake = 1'b1;
    cx = 3'd3;
    for (int i = 0; i < 33; i++) begin
      ec = (i + 1 > 31) ? 5'd31 : 5'(i + 1);
      press(SEL);
      move_seq(R, 2'b01, 1'b1, cx, 3'd3, ec, (i % 2 == 0) ? NEW : (L | SEL));
      cx = wrap7(int'(cx) + 2);
    end
    fake = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
